ov7670_capture_fmt: RTL and testbench
=====================================

Name: ov7670_capture_fmt

Overview:
- Parametrised successor to the single-byte OV7670 capture path.
- Synchronises to sensor frame timing and assembles RAW or RGB565 pixels.
- Truncates each pixel to configurable per-channel widths and writes it to a framebuffer at line-aligned addresses.
- Adds single-shot and continuous modes, frame-done strobes, a frame counter and sticky timing-error flags.

Parameters:
H_RES, 320, active pixels per line stored
V_RES, 240, lines per frame stored
ADDR_WIDTH, 17, framebuffer address width; must hold H_RES*V_RES-1
R_BITS, 1, red bits kept (1..5)
G_BITS, 1, green bits kept (1..6)
B_BITS, 1, blue bits kept (1..5)
FC_WIDTH, 8, frame counter width

Ports:
pclk  in  1  sensor pixel clock; the only clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, arms capture; ignored unless IDLE
continuous  in  1  1 = keep capturing frames; 0 = stop after the current frame
mode  in  1  0 = RAW (1 byte/pixel), 1 = RGB565 (2 bytes/pixel)
vsync  in  1  sensor vertical sync, high between frames
href  in  1  sensor line valid
d  in  8  sensor data byte
addr  out  ADDR_WIDTH  framebuffer write address
dout  out  R_BITS+G_BITS+B_BITS  pixel data, packed {R,G,B}
we  out  1  write strobe, one cycle per pixel
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at the end of each captured frame
frame_count  out  FC_WIDTH  frames completed, wraps
err  out  1  sticky timing error; cleared by start

Behaviour:
- Reset: addr=0, dout=0, we=0, busy=0, frame_done=0, frame_count=0, err=0. State goes to IDLE and all internal counters and the byte phase clear. Reset mid-frame abandons the frame with no frame_done.
- All inputs are sampled on the pclk rising edge. vsync_q is a one-cycle delayed copy used for edge detection.
- IDLE: start -> SYNC.
- SYNC: waits for a vsync falling edge (vsync_q=1, vsync=0), then moves to CAPTURE. On that transition: latch mode, clear col/line/line_base and the byte phase. Start arriving mid-frame never yields a partial frame.
- CAPTURE, vsync rising edge: frame_done=1 for one cycle and frame_count+1. Next state is SYNC if continuous=1, else IDLE. continuous is evaluated only at this edge.
- Byte phase: toggles on each href=1 cycle in RGB565 mode and is held at 0 in RAW mode. It resets to 0 whenever href=0.
- RGB565 pixel assembly:
  - byte0 = {R[4:0],G[5:3]}; byte1 = {G[2:0],B[4:0]}.
  - The pixel completes on the byte1 cycle, using byte0 from a holding register.
  - dout = {R[4 -: R_BITS], G[5 -: G_BITS], B[4 -: B_BITS]}.
- RAW pixel assembly: each byte is one pixel. dout = {d[7 -: R_BITS], d[7 -: G_BITS], d[7 -: B_BITS]}, i.e. grey replicated into all three channels.
- Write timing: we=1, addr=line_base+col and dout are registered one cycle after the edge that completes the pixel (latency 1). Afterwards col increments.
- Line end: on href falling with col>0 or a pixel in progress:
  - line+1, line_base += H_RES, col=0.
  - Short lines therefore stay grid-aligned; unwritten locations keep stale data.
- Bounds:
  - Pixel with col==H_RES: dropped (no we), err=1.
  - Any pixel with line==V_RES: dropped, err=1.
  - href falls with the byte phase at 1 (odd byte count in RGB565): half pixel discarded, err=1.
- Write gating: we is never asserted outside CAPTURE; bytes arriving in IDLE or SYNC are ignored. dout and addr hold their last values when we=0.
- Simultaneous events:
  - start in the same cycle as reset: reset wins.
  - vsync rising while href=1: frame ends; any partial pixel is discarded with no err.
  - frame_done and the last pixel write can occur in the same cycle.
- Width and wrap: frame_count wraps 2^FC_WIDTH-1 -> 0. Address arithmetic is ADDR_WIDTH bits and never exceeds H_RES*V_RES-1.

Test Plan:
1. Bench uses H_RES=4, V_RES=3, R/G/B_BITS=5/6/5. Drive start, then one full RAW frame (vsync pulse, 3 lines of 4 bytes 0x10..0x1B) -> 12 writes at addr 0..11, first dout={0x02,0x04,0x02}, one frame_done, frame_count=1, busy back to 0.
2. RGB565 line of byte pairs 0xF8,0x00 then 0x07,0xE0 -> two writes: dout=0xF800 at addr 0, then dout=0x07E0 at addr 1.
3. Assert start while vsync=0 mid-frame, with href toggling -> no we until after the next vsync falling edge; first write at addr 0.
4. Line of 6 pixels, line of 2 pixels, then a 4th line -> writes at 0..3 and 4,5; the 4th line is dropped; err=1. The next start clears err.
5. continuous=1 for 3 frames, deassert it during frame 3 -> frame_done pulses 3 times, frame_count=3, IDLE after frame 3. With FC_WIDTH=2 and 5 frames, frame_count=1.
6. Assert reset mid-line -> all outputs are 0 on the next cycle and no frame_done; after restart, the first write is at addr 0.

Source files
------------

// File: rtl/ov7670_capture_fmt.sv
// ov7670_capture_fmt
// Captures frames from an OV7670-style sensor bus, assembles RAW (1 byte per
// pixel) or RGB565 (2 bytes per pixel) pixels, truncates them to R/G/B_BITS
// and writes them to a framebuffer at line-aligned addresses
// (line * H_RES + col).
//
// Ports:
//   pclk         sensor pixel clock, the only clock
//   reset        synchronous, active-high reset
//   start        one-cycle pulse, arms a capture (only accepted in IDLE)
//   continuous   1 = re-arm after every frame, 0 = stop after this frame
//   mode         0 = RAW, 1 = RGB565 (latched at the start of each frame)
//   vsync        sensor vertical sync, high between frames
//   href         sensor line valid
//   d            sensor data byte
//   addr         framebuffer write address
//   dout         pixel data packed {R,G,B}
//   we           write strobe, one cycle per stored pixel
//   busy         high whenever the capture engine is not IDLE
//   frame_done   one-cycle pulse when a captured frame ends
//   frame_count  number of completed frames, wraps
//   err          sticky timing error, cleared by an accepted start
module ov7670_capture_fmt #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_WIDTH = 17,
  parameter int R_BITS     = 1,
  parameter int G_BITS     = 1,
  parameter int B_BITS     = 1,
  parameter int FC_WIDTH   = 8
) (
  input  logic                             pclk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             continuous,
  input  logic                             mode,
  input  logic                             vsync,
  input  logic                             href,
  input  logic [7:0]                       d,
  output logic [ADDR_WIDTH-1:0]            addr,
  output logic [R_BITS+G_BITS+B_BITS-1:0]  dout,
  output logic                             we,
  output logic                             busy,
  output logic                             frame_done,
  output logic [FC_WIDTH-1:0]              frame_count,
  output logic                             err
);

  localparam int DW = R_BITS + G_BITS + B_BITS;
  // col and line saturate at H_RES / V_RES, so they need one extra code.
  localparam int CW = $clog2(H_RES + 1);
  localparam int LW = $clog2(V_RES + 1);
  localparam logic [CW-1:0]         H_MAX  = CW'(H_RES);
  localparam logic [LW-1:0]         V_MAX  = LW'(V_RES);
  localparam logic [ADDR_WIDTH-1:0] H_STEP = ADDR_WIDTH'(H_RES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state_q;
  logic                  vsync_q;
  logic                  href_q;
  logic                  mode_q;
  logic                  phase_q;
  logic [7:0]            byte0_q;
  logic [CW-1:0]         col_q;
  logic [LW-1:0]         line_q;
  logic [ADDR_WIDTH-1:0] line_base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DW-1:0]         dout_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic [FC_WIDTH-1:0]   frame_count_q;
  logic                  err_q;

  logic          vs_fall_s;
  logic          vs_rise_s;
  logic          href_fall_s;
  logic          pix_done_s;
  logic          pix_ok_s;
  logic [DW-1:0] pix_data_s;

  // RGB565: byte0 = {R[4:0],G[5:3]}, byte1 = {G[2:0],B[4:0]}; keep the MSBs.
  function automatic logic [DW-1:0] pack_rgb(input logic [7:0] b0, input logic [7:0] b1);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = b0[7:3];
    g = {b0[2:0], b1[7:5]};
    b = b1[4:0];
    return {r[4 -: R_BITS], g[5 -: G_BITS], b[4 -: B_BITS]};
  endfunction

  // RAW: the grey byte is replicated into all three channels.
  function automatic logic [DW-1:0] pack_raw(input logic [7:0] g8);
    return {g8[7 -: R_BITS], g8[7 -: G_BITS], g8[7 -: B_BITS]};
  endfunction

  // Edge detection and pixel completion for the current byte.
  always_comb begin
    vs_fall_s   = vsync_q & ~vsync;
    vs_rise_s   = ~vsync_q & vsync;
    href_fall_s = href_q & ~href;
    // A vsync rise ends the frame, so a byte in that cycle is never stored.
    pix_done_s  = (state_q == CAPTURE) && href && !vs_rise_s && (!mode_q || phase_q);
    pix_ok_s    = (col_q < H_MAX) && (line_q < V_MAX);
    if (mode_q) begin
      pix_data_s = pack_rgb(byte0_q, d);
    end else begin
      pix_data_s = pack_raw(d);
    end
  end

  // Capture FSM, pixel counters and all registered outputs.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q       <= IDLE;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      mode_q        <= 1'b0;
      phase_q       <= 1'b0;
      byte0_q       <= 8'd0;
      col_q         <= '0;
      line_q        <= '0;
      line_base_q   <= '0;
      addr_q        <= '0;
      dout_q        <= '0;
      we_q          <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      href_q       <= href;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SYNC;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        SYNC: begin
          // Only a fresh frame start is accepted, never a frame in progress.
          if (vs_fall_s) begin
            state_q     <= CAPTURE;
            mode_q      <= mode;
            col_q       <= '0;
            line_q      <= '0;
            line_base_q <= '0;
            phase_q     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise_s) begin
            // Any partial pixel is silently dropped at frame end.
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 1'b1;
            phase_q       <= 1'b0;
            if (continuous) begin
              state_q <= SYNC;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (href) begin
            phase_q <= mode_q ? ~phase_q : 1'b0;
            if (mode_q && !phase_q) begin
              byte0_q <= d;
            end
            if (pix_done_s) begin
              if (pix_ok_s) begin
                we_q   <= 1'b1;
                addr_q <= line_base_q + ADDR_WIDTH'(col_q);
                dout_q <= pix_data_s;
                col_q  <= col_q + 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end else begin
            phase_q <= 1'b0;
            // Lines with any byte advance the grid, even if short.
            if (href_fall_s && ((col_q != '0) || phase_q)) begin
              col_q <= '0;
              if (line_q < V_MAX) begin
                line_q      <= line_q + 1'b1;
                line_base_q <= line_base_q + H_STEP;
              end
              if (phase_q) begin
                err_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr        = addr_q;
  assign dout        = dout_q;
  assign we          = we_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ov7670_capture_fmt.sv
// Testbench for ov7670_capture_fmt: H_RES=4, V_RES=3, RGB 5/6/5.
// A second instance with FC_WIDTH=2 shares all inputs to exercise counter wrap.
module tb_ov7670_capture_fmt;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          pclk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          mode = 1'b0;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic [7:0]    d = 8'd0;

  logic [AW-1:0] addr, addr2;
  logic [DW-1:0] dout, dout2;
  logic          we, we2, busy, busy2, frame_done, frame_done2, err, err2;
  logic [7:0]    frame_count;
  logic [1:0]    frame_count2;

  ov7670_capture_fmt #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(AW), .R_BITS(5), .G_BITS(6),
                       .B_BITS(5), .FC_WIDTH(8)) dut (
    .pclk(pclk), .reset(reset), .start(start), .continuous(continuous), .mode(mode),
    .vsync(vsync), .href(href), .d(d), .addr(addr), .dout(dout), .we(we), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .err(err));

  ov7670_capture_fmt #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(AW), .R_BITS(5), .G_BITS(6),
                       .B_BITS(5), .FC_WIDTH(2)) dut2 (
    .pclk(pclk), .reset(reset), .start(start), .continuous(continuous), .mode(mode),
    .vsync(vsync), .href(href), .d(d), .addr(addr2), .dout(dout2), .we(we2), .busy(busy2),
    .frame_done(frame_done2), .frame_count(frame_count2), .err(err2));

  always #5 pclk = ~pclk;

  int checks = 0;
  int fails  = 0;

  // Scoreboard queues: expected writes {addr,dout} and expected frame_count at frame_done.
  logic [31:0] exp_wr[$];
  int          exp_fd[$];

  // Reference model state (frame level).
  int   mfc   = 0;
  bit   merr  = 1'b0;
  int   mline = 0;
  bit   mmode = 1'b0;
  bit   idle_exp = 1'b1;
  logic [7:0] lbuf[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] raw_exp(input logic [7:0] v);
    int r, g, b;
    r = int'(v) / 8;
    g = int'(v) / 4;
    b = int'(v) / 8;
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  // Monitor: compare every DUT write and frame_done against the scoreboard.
  always @(negedge pclk) begin
    if (!reset) begin
      if (we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL wr_unexpected: addr=%0d dout=0x%0h with nothing expected", addr, dout);
        end else begin
          logic [31:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", int'(addr), int'(e[31:16]));
          check("wr_dout", int'(dout), int'(e[15:0]));
        end
      end
      if (frame_done) begin
        if (exp_fd.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL fd_unexpected: frame_done with count %0d not expected", frame_count);
        end else begin
          check("fd_count", int'(frame_count), exp_fd.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    merr = 1'b0;
    idle_exp = 1'b0;
  endtask

  task automatic begin_frame(input bit m, input bit c);
    if (idle_exp) pulse_start();
    mode = m;
    continuous = c;
    vsync = 1'b1;
    repeat (2) tick();
    vsync = 1'b0;
    tick();
    mline = 0;
    mmode = m;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Model the line from the rules first, then drive its bytes.
  task automatic send_line(input logic [7:0] b[$]);
    int n;
    int np;
    logic [15:0] v;
    n  = b.size();
    np = mmode ? n / 2 : n;
    if (mmode && (n % 2) == 1) merr = 1'b1;
    for (int k = 0; k < np; k++) begin
      v = mmode ? {b[2*k], b[2*k+1]} : raw_exp(b[k]);
      if (mline < V && k < H) exp_wr.push_back({16'(mline * H + k), v});
      else merr = 1'b1;
    end
    if (n > 0) mline++;
    for (int i = 0; i < n; i++) begin
      d = b[i];
      href = 1'b1;
      tick();
    end
    href = 1'b0;
    d = 8'($urandom);
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic rand_line(input int n);
    lbuf = {};
    for (int i = 0; i < n; i++) lbuf.push_back(8'($urandom));
    send_line(lbuf);
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    mfc++;
    exp_fd.push_back(mfc % 256);
    repeat (3) tick();
    idle_exp = !continuous;
    check("busy_after_frame", int'(busy), int'(continuous));
    check("frame_count", int'(frame_count), mfc % 256);
    check("frame_count_w2", int'(frame_count2), mfc % 4);
    check("err", int'(err), int'(merr));
    check("wr_queue_drained", exp_wr.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, int'(addr), 0);
    check({tag, "_dout"}, int'(dout), 0);
    check({tag, "_we"}, int'(we), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_frame_count"}, int'(frame_count), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    // Reset state, with start asserted alongside reset (reset wins).
    reset = 1'b1;
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check("idle_after_reset_busy", int'(busy), 0);

    // RAW frame, 3 lines of bytes 0x10..0x1B.
    begin_frame(1'b0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      lbuf = {};
      for (int i = 0; i < 4; i++) lbuf.push_back(8'(16 + l * 4 + i));
      send_line(lbuf);
    end
    end_frame();

    // RGB565 line F8 00 07 E0.
    begin_frame(1'b1, 1'b0);
    lbuf = {8'hF8, 8'h00, 8'h07, 8'hE0};
    send_line(lbuf);
    end_frame();

    // Start mid-frame with href toggling: nothing stored until the next frame.
    vsync = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      href = (i % 4) != 3;
      d = 8'($urandom);
      if (i == 5) start = 1'b1;
      tick();
      if (i == 5) begin
        start = 1'b0;
        merr = 1'b0;
        idle_exp = 1'b0;
      end
    end
    href = 1'b0;
    tick();
    check("midframe_busy", int'(busy), 1);
    begin_frame(1'b0, 1'b0);
    rand_line(4);
    end_frame();

    // Over-long line, short line, full line, then an extra line: bounds and err.
    begin_frame(1'b0, 1'b0);
    rand_line(6);
    rand_line(2);
    rand_line(4);
    rand_line(3);
    end_frame();
    pulse_start();
    check("err_cleared_by_start", int'(err), 0);

    // Odd byte count in RGB565 mode.
    begin_frame(1'b1, 1'b0);
    rand_line(5);
    rand_line(4);
    end_frame();

    // Reset in the middle of an RGB565 line: no frame_done, outputs cleared.
    begin_frame(1'b1, 1'b0);
    rand_line(4);
    d = 8'($urandom);
    href = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("midline_reset");
    reset = 1'b0;
    href = 1'b0;
    mfc = 0;
    merr = 1'b0;
    idle_exp = 1'b1;
    vsync = 1'b1;
    repeat (3) tick();
    begin_frame(1'b0, 1'b0);
    rand_line(3);
    end_frame();

    // Continuous mode for 3 frames, deasserted during the third.
    for (int f = 0; f < 3; f++) begin
      begin_frame(1'($urandom), 1'b1);
      rand_line(4);
      rand_line(2);
      if (f == 2) continuous = 1'b0;
      end_frame();
    end
    check("idle_after_continuous", int'(busy), 0);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      int nl;
      bit m;
      m  = 1'($urandom);
      nl = $urandom_range(0, 4);
      begin_frame(m, 1'($urandom));
      for (int l = 0; l < nl; l++) rand_line($urandom_range(0, m ? 11 : 6));
      end_frame();
    end

    repeat (4) tick();
    check("final_wr_queue", exp_wr.size(), 0);
    check("final_fd_queue", exp_fd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
